am_handler_dispatch: RTL and testbench
======================================

// Module: am_handler_dispatch
// PURPOSE
//   Parametrised successor to the GAScore handler front-end. Accepts the single AM handler
//   AXI-Stream from the GAScore, decodes each packet header and routes the packet to one of
//   NUM_KERNELS per-kernel output streams. Each output stream has its own FIFO, so a stalled
//   kernel does not block delivery already buffered for the others. Packets whose destination
//   is out of range are dropped and counted instead of hanging the stream.
// PARAMETERS
//   NUM_KERNELS    2   number of output channels, 1..16
//   DATA_WIDTH     64  stream data width, >= max(DEST_LSB+DEST_WIDTH, HANDLER_LSB+HANDLER_WIDTH)
//   DEST_LSB       24  LSB of destination kernel ID field in header beat
//   DEST_WIDTH     16  width of destination field (address_offset width matches)
//   HANDLER_LSB    56  LSB of AM handler ID field in header beat
//   HANDLER_WIDTH  4   width of handler ID
//   FIFO_DEPTH     4   entries per channel FIFO, power of two, >= 2
//   FORWARD_HEADER 0   1: header beat forwarded as first beat; 0: header stripped
// PORTS
//   clock           in   1                       single clock domain
//   reset_n         in   1                       synchronous, active-low reset
//   address_offset  in   DEST_WIDTH              subtracted from header dest to get local index
//   s_axis_tdata    in   DATA_WIDTH              input stream data
//   s_axis_tlast    in   1                       input end of packet
//   s_axis_tvalid   in   1                       input valid
//   s_axis_tready   out  1                       input ready
//   m_axis_tdata    out  NUM_KERNELS*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tlast    out  NUM_KERNELS             per-channel last
//   m_axis_tvalid   out  NUM_KERNELS             per-channel valid
//   m_axis_tready   in   NUM_KERNELS             per-channel ready
//   m_handler       out  NUM_KERNELS*HANDLER_WIDTH  handler ID travelling with head FIFO entry
//   drop_count      out  16                      dropped-packet counter, saturating
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): state=ST_HEADER, all FIFOs empty, m_axis_tvalid=0,
//     drop_count=0. s_axis_tready=0 while reset_n=0. Reset mid-packet discards packet
//     state; the next accepted beat is treated as a header.
//   dest = (s_axis_tdata[DEST_LSB+:DEST_WIDTH] - address_offset) mod 2^DEST_WIDTH.
//     valid_dest = dest < NUM_KERNELS.
//   FSM:
//     ST_HEADER:  valid_dest: tready = !full[dest]. On accept latch sel=dest and
//                 hid=tdata[HANDLER_LSB+:HANDLER_WIDTH].
//                   FORWARD_HEADER=1: push header beat with its tlast.
//                   FORWARD_HEADER=0, tlast=0: no push.
//                   FORWARD_HEADER=0, tlast=1: push one beat {tdata=header, tlast=1}.
//                   Next state: tlast ? ST_HEADER : ST_PAYLOAD.
//                 !valid_dest: tready=1. On accept drop_count++ (saturates at 16'hFFFF).
//                   Next state: tlast ? ST_HEADER : ST_DROP.
//     ST_PAYLOAD: tready = !full[sel]. Push each accepted beat {tdata, tlast, hid} to FIFO sel.
//                 tlast accepted -> ST_HEADER.
//     ST_DROP:    tready=1, beats discarded. tlast accepted -> ST_HEADER.
//   FIFO entry = {hid, tlast, tdata}. Latency: beat accepted at edge t is visible on
//     m_axis_* after edge t (FIFO output registered; no combinational in->out path).
//   full[k] = (count[k] == FIFO_DEPTH). No push-through when full, even with a same-cycle pop.
//   Simultaneous push and pop on one channel: count unchanged, order preserved.
//   m_axis_tvalid[k] = (count[k] != 0). Head entry held stable until m_axis_tready[k].
//   Pointer wrap is modulo FIFO_DEPTH. The count width holds 0..FIFO_DEPTH inclusive.
//   Input tready never depends on s_axis_tvalid. Output channels are independent.
// TESTING
//   T1 NUM_KERNELS=2, offset=0x10, header dest=0x11, hid=3, 3 payload beats, all readies=1
//      -> ch1 gets 3 beats (FORWARD_HEADER=0), tlast on 3rd, m_handler[1]=3; ch0 idle.
//   T2 Header-only packet (tlast on header), dest=offset+0, FORWARD_HEADER=0
//      -> ch0 gets one beat, tdata=header, tlast=1.
//   T3 dest=offset+5 with NUM_KERNELS=2, 4-beat packet -> all beats accepted at tready=1,
//      nothing on outputs, drop_count=1. 0x10000 drops -> drop_count holds 0xFFFF.
//   T4 FIFO_DEPTH=4, m_axis_tready[0]=0, 8-beat packet to ch0 -> tready falls after 4 pushed;
//      then assert ready -> all 8 beats delivered in order, none lost or duplicated.
//   T5 ch0 stalled full, next packet to ch1 -> ch1 packet blocked until ch0 packet finishes,
//      then ch1 drains while ch0 stays full.
//   T6 reset_n=0 for one cycle mid-payload -> FIFOs empty, tvalid=0, drop_count=0;
//      next beat decoded as header.

Source files
------------

// File: rtl/am_handler_dispatch.sv
// ---------------------------------------------------------------------------
// am_handler_dispatch
//   Takes the single AM handler stream from the GAScore and decodes the
//   header beat of each packet. The packet is then steered into one of
//   NUM_KERNELS per-kernel output streams. Every output channel has its own
//   FIFO, so a stalled kernel only blocks traffic that is headed for it.
//   A packet whose destination is out of range is swallowed and counted.
//
// Ports
//   clock, reset_n      single clock; synchronous active-low reset
//   address_offset      subtracted from the header dest field to get the local index
//   s_axis_*            input AXI-Stream (tdata/tlast/tvalid/tready)
//   m_axis_*            NUM_KERNELS output streams, channel k at slice k
//   m_handler           handler ID carried with each channel's head entry
//   drop_count          saturating count of dropped packets
// ---------------------------------------------------------------------------

// Per-channel FIFO. The head is read straight out of the storage registers,
// so a beat pushed at edge t becomes visible after edge t. There is no
// combinational input-to-output path.
module am_chan_fifo #(
    parameter int EW    = 69,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [EW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          valid_o,
    output logic [EW-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    // No push-through: a full FIFO refuses a push even when it is popped in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end
endmodule

module am_handler_dispatch #(
    parameter int NUM_KERNELS    = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int DEST_LSB       = 24,
    parameter int DEST_WIDTH     = 16,
    parameter int HANDLER_LSB    = 56,
    parameter int HANDLER_WIDTH  = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int FORWARD_HEADER = 0
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [DEST_WIDTH-1:0]                address_offset,
    input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic                                 s_axis_tlast,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    output logic [NUM_KERNELS*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [NUM_KERNELS-1:0]               m_axis_tlast,
    output logic [NUM_KERNELS-1:0]               m_axis_tvalid,
    input  logic [NUM_KERNELS-1:0]               m_axis_tready,
    output logic [NUM_KERNELS*HANDLER_WIDTH-1:0] m_handler,
    output logic [15:0]                          drop_count
);
    localparam int SEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
    localparam int EW    = HANDLER_WIDTH + 1 + DATA_WIDTH;
    localparam int CMPW  = (DEST_WIDTH > 32) ? DEST_WIDTH : 32;

    typedef enum logic [1:0] {ST_HEADER, ST_PAYLOAD, ST_DROP} state_t;

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [HANDLER_WIDTH-1:0] hid_q, hid_d;
    logic [15:0]              drop_q, drop_d;

    logic [DEST_WIDTH-1:0]    dest;
    logic                     valid_dest;
    logic [SEL_W-1:0]         dest_idx;
    logic [HANDLER_WIDTH-1:0] hdr_hid;
    logic [NUM_KERNELS-1:0]   full;
    logic                     ready_raw;
    logic                     accept;
    logic                     push;
    logic [SEL_W-1:0]         push_sel;
    logic [EW-1:0]            push_entry;

    // Modular subtraction: dest values below the offset wrap high and count as out of range.
    assign dest       = s_axis_tdata[DEST_LSB +: DEST_WIDTH] - address_offset;
    assign valid_dest = CMPW'(dest) < CMPW'(NUM_KERNELS);
    assign dest_idx   = SEL_W'(dest);
    assign hdr_hid    = s_axis_tdata[HANDLER_LSB +: HANDLER_WIDTH];

    // Ready depends only on the state, the decoded header and FIFO fullness.
    // It never depends on tvalid.
    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            ST_HEADER:  ready_raw = valid_dest ? !full[dest_idx] : 1'b1;
            ST_PAYLOAD: ready_raw = !full[sel_q];
            ST_DROP:    ready_raw = 1'b1;
            default:    ready_raw = 1'b0;
        endcase
    end

    assign s_axis_tready = reset_n && ready_raw;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        hid_d      = hid_q;
        drop_d     = drop_q;
        push       = 1'b0;
        push_sel   = sel_q;
        push_entry = {hid_q, s_axis_tlast, s_axis_tdata};
        case (state_q)
            ST_HEADER: begin
                if (valid_dest) begin
                    push_sel   = dest_idx;
                    push_entry = {hdr_hid, s_axis_tlast, s_axis_tdata};
                    // When headers are stripped, a header-only packet still delivers one beat,
                    // so the kernel sees the request.
                    push       = accept && ((FORWARD_HEADER != 0) || s_axis_tlast);
                    if (accept) begin
                        sel_d   = dest_idx;
                        hid_d   = hdr_hid;
                        state_d = s_axis_tlast ? ST_HEADER : ST_PAYLOAD;
                    end
                end else if (accept) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    state_d = s_axis_tlast ? ST_HEADER : ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                push = accept;
                if (accept && s_axis_tlast) state_d = ST_HEADER;
            end
            ST_DROP: begin
                if (accept && s_axis_tlast) state_d = ST_HEADER;
            end
            default: state_d = ST_HEADER;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_HEADER;
            sel_q   <= '0;
            hid_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hid_q   <= hid_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_count = drop_q;

    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_ch
        logic [EW-1:0] head;

        am_chan_fifo #(
            .EW    (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock       (clock),
            .reset_n     (reset_n),
            .push_i      (push && (push_sel == SEL_W'(k))),
            .push_data_i (push_entry),
            .pop_i       (m_axis_tready[k]),
            .full_o      (full[k]),
            .valid_o     (m_axis_tvalid[k]),
            .head_o      (head)
        );

        assign m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]       = head[DATA_WIDTH-1:0];
        assign m_axis_tlast[k]                                = head[DATA_WIDTH];
        assign m_handler[k*HANDLER_WIDTH +: HANDLER_WIDTH]    = head[EW-1 -: HANDLER_WIDTH];
    end
endmodule

// File: tb/tb_am_handler_dispatch.sv
module tb_am_handler_dispatch;
    localparam int NK = 2;
    localparam int DW = 64;
    localparam int HW = 4;
    localparam int EW = HW + 1 + DW;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [15:0]         address_offset;
    logic [DW-1:0]       s_axis_tdata;
    logic                s_axis_tlast;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic [NK*DW-1:0]    m_axis_tdata;
    logic [NK-1:0]       m_axis_tlast;
    logic [NK-1:0]       m_axis_tvalid;
    logic [NK-1:0]       m_axis_tready;
    logic [NK*HW-1:0]    m_handler;
    logic [15:0]         drop_count;

    always #5 clock = ~clock;

    am_handler_dispatch #(
        .NUM_KERNELS(NK), .DATA_WIDTH(DW), .DEST_LSB(24), .DEST_WIDTH(16),
        .HANDLER_LSB(56), .HANDLER_WIDTH(HW), .FIFO_DEPTH(4), .FORWARD_HEADER(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address_offset(address_offset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_handler(m_handler), .drop_count(drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];

    typedef struct {
        logic [15:0] dest;
        logic [3:0]  hid;
        int          npay;   // payload beats; 0 = header-only packet
        int          ch;     // expected channel, -1 = dropped
        logic [15:0] drops;  // drop_count expected after this packet
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: each output beat that is handshaken is compared with the front of its channel queue.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int k = 0; k < NK; k++) begin
                if (m_axis_tvalid[k] && m_axis_tready[k]) begin
                    logic [EW-1:0] got;
                    logic [EW-1:0] exp;
                    got = {m_handler[k*HW +: HW], m_axis_tlast[k], m_axis_tdata[k*DW +: DW]};
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, got);
                    end else begin
                        exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("ch%0d_beat", k), 128'(got), 128'(exp));
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk_hdr(input logic [15:0] dest, input logic [3:0] hid,
                                             input logic [23:0] tag);
        logic [DW-1:0] h;
        h        = '0;
        h[63:60] = 4'h9;
        h[59:56] = hid;
        h[55:40] = 16'hBEEF;
        h[39:24] = dest;
        h[23:0]  = tag;
        return h;
    endfunction

    function automatic logic [DW-1:0] mk_pay(input int tag, input int b);
        return {16'(tag), 16'(b), 32'hCAFE0000 + 32'(b)};
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input int ch,
                             input logic [3:0] hid, input bit push);
        int cyc;
        cyc = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clock);
        while (!s_axis_tready && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        if (!s_axis_tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: tready 0 for beat %0h, required 1", d);
        end else if (push) begin
            if (ch == 0) q0.push_back({hid, l, d});
            else         q1.push_back({hid, l, d});
        end
        @(posedge clock);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] dest, input logic [3:0] hid, input int npay,
                            input int ch, input int tag);
        send_beat(mk_hdr(dest, hid, 24'(tag)), npay == 0, ch, hid, (ch >= 0) && (npay == 0));
        for (int b = 0; b < npay; b++)
            send_beat(mk_pay(tag, b), b == npay - 1, ch, hid, ch >= 0);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        @(negedge clock);
        chk(name, 128'(q0.size() + q1.size()), 128'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nsat;
        tbl[0] = '{16'h0011, 4'h3, 3, 1, 16'd0};   // ch1, 3 payload beats
        tbl[1] = '{16'h0010, 4'h5, 0, 0, 16'd0};   // header-only to ch0
        tbl[2] = '{16'h0015, 4'h1, 3, -1, 16'd1};  // out of range, 4-beat packet
        tbl[3] = '{16'h0010, 4'hA, 2, 0, 16'd1};
        tbl[4] = '{16'h000F, 4'h2, 1, -1, 16'd2};  // below offset wraps to 0xFFFF
        tbl[5] = '{16'h0011, 4'hF, 0, 1, 16'd2};
        tbl[6] = '{16'h0012, 4'h7, 2, -1, 16'd3};  // first index past the last kernel

        reset_n        = 1'b0;
        address_offset = 16'h0010;
        s_axis_tdata   = '0;
        s_axis_tlast   = 1'b0;
        s_axis_tvalid  = 1'b0;
        m_axis_tready  = '1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_s_tready", 128'(s_axis_tready), 128'(0));
        chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_drop_count", 128'(drop_count), 128'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Table-driven packets
        for (int i = 0; i < 7; i++) begin
            send_pkt(tbl[i].dest, tbl[i].hid, tbl[i].npay, tbl[i].ch, i + 1);
            wait_drain($sformatf("vec%0d_drain", i));
            chk($sformatf("vec%0d_drop_count", i), 128'(drop_count), 128'(tbl[i].drops));
        end

        // Backpressure: an 8-beat packet to a stalled ch0 stops after 4 beats
        m_axis_tready[0] = 1'b0;
        send_beat(mk_hdr(16'h0010, 4'h6, 24'h40), 1'b0, 0, 4'h6, 1'b0);
        for (int b = 0; b < 4; b++) send_beat(mk_pay(40, b), 1'b0, 0, 4'h6, 1'b1);
        s_axis_tdata  = mk_pay(40, 4);
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(negedge clock);
        chk("bp_tready_full", 128'(s_axis_tready), 128'(0));
        chk("bp_head_valid", 128'(m_axis_tvalid[0]), 128'(1));
        chk("bp_head_stable", 128'(m_axis_tdata[DW-1:0]), 128'(mk_pay(40, 0)));
        @(posedge clock);
        #1;
        m_axis_tready[0] = 1'b1;
        for (int b = 4; b < 8; b++) send_beat(mk_pay(40, b), b == 7, 0, 4'h6, 1'b1);
        wait_drain("bp_drain");

        // Channel independence: ch0 stays full while ch1 drains
        m_axis_tready[0] = 1'b0;
        send_pkt(16'h0010, 4'h8, 4, 0, 50);
        send_pkt(16'h0011, 4'h9, 3, 1, 51);
        begin
            int cyc;
            cyc = 0;
            while (q1.size() != 0 && cyc < 100) begin
                @(negedge clock);
                cyc++;
            end
        end
        @(negedge clock);
        chk("ind_ch1_drained", 128'(q1.size()), 128'(0));
        chk("ind_ch0_held", 128'(m_axis_tvalid[0]), 128'(1));
        chk("ind_ch0_pending", 128'(q0.size()), 128'(4));
        @(posedge clock);
        #1;
        s_axis_tdata  = mk_hdr(16'h0010, 4'hB, 24'h52);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge clock);
        chk("ind_hdr_to_full_blocked", 128'(s_axis_tready), 128'(0));
        @(posedge clock);
        #1;
        m_axis_tready[0] = 1'b1;
        send_beat(mk_hdr(16'h0010, 4'hB, 24'h52), 1'b1, 0, 4'hB, 1'b1);
        wait_drain("ind_drain");

        // Drop counter saturation
        nsat = 65535 - int'(tbl[6].drops);
        for (int i = 0; i < nsat; i++) send_beat(mk_hdr(16'h0015, 4'h0, 24'(i)), 1'b1, -1, 4'h0, 1'b0);
        @(negedge clock);
        chk("sat_reach_max", 128'(drop_count), 128'(16'hFFFF));
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) send_beat(mk_hdr(16'h0002, 4'h0, 24'(i)), 1'b1, -1, 4'h0, 1'b0);
        @(negedge clock);
        chk("sat_hold_max", 128'(drop_count), 128'(16'hFFFF));
        @(posedge clock);
        #1;

        // Reset in the middle of a payload
        m_axis_tready[1] = 1'b0;
        send_beat(mk_hdr(16'h0011, 4'h2, 24'h60), 1'b0, 1, 4'h2, 1'b0);
        send_beat(mk_pay(60, 0), 1'b0, 1, 4'h2, 1'b1);
        @(negedge clock);
        chk("mid_rst_pre_valid", 128'(m_axis_tvalid[1]), 128'(1));
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_s_tready", 128'(s_axis_tready), 128'(0));
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("mid_rst_drop_count", 128'(drop_count), 128'(0));
        q0.delete();
        q1.delete();
        @(posedge clock);
        #1;
        reset_n          = 1'b1;
        m_axis_tready[1] = 1'b1;
        // A header-only beat would be a payload beat if the old packet state had survived
        send_pkt(16'h0010, 4'hC, 0, 0, 70);
        wait_drain("post_rst_drain");
        chk("post_rst_drop_count", 128'(drop_count), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
